// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble: shift right, then
// subtract 3 from every BCD digit that is >= 8), with start/busy/done handshake.
module bcd_to_bin #(
    parameter int DIGITS    = 3,
    parameter int BIN_W     = 10,
    parameter int OVF_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  ovf,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int W_W   = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W_W-1:0]   r_work;
    logic             r_busy;
    logic             r_done;
    logic [BIN_W-1:0] r_bin;
    logic             r_ovf;
    logic             r_err;

    logic [W_W-1:0]   w_shift;
    logic [W_W-1:0]   w_next;
    logic             w_bad;

    // Shift first, then correct every digit of the shifted value in parallel.
    always_comb begin
        w_shift = r_work >> 1;
        w_next  = w_shift;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_shift[BIN_W + 4*d +: 4] >= 4'd8)
                w_next[BIN_W + 4*d +: 4] = w_shift[BIN_W + 4*d +: 4] - 4'd3;
        end
    end

    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9)
                w_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_bad) begin
                            r_err  <= 1'b1;
                            r_bin  <= '0;
                            r_ovf  <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_work  <= {bcd, {BIN_W{1'b0}}};
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                            r_state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_bin   <= w_shift[BIN_W-1:0];
                        r_ovf   <= (w_shift[BIN_W-1:0] > BIN_W'(OVF_LIMIT));
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bin  = r_bin;
    assign ovf  = r_ovf;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed, table-driven bench for bcd_to_bin (DIGITS=3, BIN_W=10, OVF_LIMIT=255).
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [9:0]  bin;
    logic        ovf;
    logic        err;

    int n_cmp;
    int n_bad;

    bcd_to_bin #(.DIGITS(3), .BIN_W(10), .OVF_LIMIT(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .ovf   (ovf),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called #1 after an edge; start is seen by the next edge (E0).
    task automatic start_req(input logic [11:0] v);
        start = 1'b1;
        bcd   = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // From #1 after E0: edges until done is seen, and cycles busy was high.
    task automatic wait_done(output int n, output int bc, output int seen);
        n = 0; bc = 0; seen = 0;
        while (!done && n < 20) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        seen = int'(done);
    endtask

    initial begin
        int n, bc, seen, pulses;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; bcd = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bin",  int'(bin),  0);
        chk("rst_ovf",  int'(ovf),  0);
        chk("rst_err",  int'(err),  0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vt[0] = '{12'h099, 10'h063, 1'b0, 1'b0};
        vt[1] = '{12'h255, 10'h0FF, 1'b0, 1'b0};
        vt[2] = '{12'h256, 10'h100, 1'b1, 1'b0};
        vt[3] = '{12'h0A5, 10'h000, 1'b0, 1'b1};
        vt[4] = '{12'h042, 10'h02A, 1'b0, 1'b0};
        vt[5] = '{12'h999, 10'h3E7, 1'b1, 1'b0};

        for (int i = 0; i < 6; i++) begin
            start_req(vt[i].bcd);
            wait_done(n, bc, seen);
            chk($sformatf("v%0d_done", i), seen, 1);
            chk($sformatf("v%0d_lat", i), n, vt[i].err ? 0 : 10);
            chk($sformatf("v%0d_busy", i), bc, vt[i].err ? 0 : 10);
            chk($sformatf("v%0d_bin", i), int'(bin), int'(vt[i].bin));
            chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vt[i].ovf));
            chk($sformatf("v%0d_err", i), int'(err), int'(vt[i].err));
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), int'(done), 0);
            chk($sformatf("v%0d_hold", i), int'(bin), int'(vt[i].bin));
        end

        // Reset mid-conversion: outputs clear asynchronously, no done follows.
        start_req(12'h999);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #2;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_bin",  int'(bin),  0);
        chk("mrst_ovf",  int'(ovf),  0);
        chk("mrst_err",  int'(err),  0);
        chk("mrst_done", int'(done), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("mrst_nodone", pulses, 0);
        start_req(12'h000);
        wait_done(n, bc, seen);
        chk("zero_done", seen, 1);
        chk("zero_lat", n, 10);
        chk("zero_bin", int'(bin), 0);
        chk("zero_ovf", int'(ovf), 0);
        chk("zero_err", int'(err), 0);
        @(posedge clk); #1;

        // Start while busy is ignored.
        start_req(12'h123);
        repeat (2) @(posedge clk);
        #1;
        start_req(12'h999);
        pulses = 0;
        repeat (20) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        chk("busy_pulses", pulses, 1);
        chk("busy_bin", int'(bin), 10'h07B);
        chk("busy_ovf", int'(ovf), 0);

        // Back-to-back: new start in the done cycle.
        start_req(12'h321);
        repeat (3) @(posedge clk);
        #1 bcd = 12'h000;
        wait_done(n, bc, seen);
        chk("hold_done", seen, 1);
        chk("hold_bin", int'(bin), 10'h141);
        chk("b2b_done_hi", int'(done), 1);
        start_req(12'h500);
        chk("b2b_busy", int'(busy), 1);
        wait_done(n, bc, seen);
        chk("b2b_seen", seen, 1);
        chk("b2b_lat", n, 10);
        chk("b2b_bin", int'(bin), 10'h1F4);
        chk("b2b_ovf", int'(ovf), 1);
        chk("b2b_err", int'(err), 0);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
